rule110_frame_rx: RTL and testbench

Receive side of the Rule 110 generation stream: accepts the 16-bit words that the automaton top emits on its output pins, reassembles each 256-cell generation, and publishes it as one wide word. It also recomputes the expected next generation from the previous frame and flags mismatches, giving the team an on-chip or bench-side checker for the automaton output path.

---
 rtl/rule110_pkg.sv | 11 +
 rtl/rule110_step.sv | 15 +
 rtl/rule110_frame_rx.sv | 114 +++++++++++
 tb/tb_rule110_frame_rx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule110_pkg.sv
// Constants and FSM encoding shared by the Rule 110 automaton and its frame receiver.
package rule110_pkg;
  localparam int CELLS = 256;
  localparam int WORD  = 16;
  localparam int WORDS = CELLS / WORD;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;
endpackage

// File: rtl/rule110_step.sv
// Combinational Rule 110 next-generation function; cells beyond either edge read as 0.
module rule110_step
  import rule110_pkg::*;
(
  input  logic [CELLS-1:0] cur_i,
  output logic [CELLS-1:0] nxt_o
);
  logic [CELLS-1:0] left;
  logic [CELLS-1:0] right;

  // left[i] = cur[i+1], right[i] = cur[i-1]
  assign left  = {1'b0, cur_i[CELLS-1:1]};
  assign right = {cur_i[CELLS-2:0], 1'b0};
  assign nxt_o = (left & cur_i & ~right) | (~left & cur_i) | (~cur_i & right);
endmodule

// File: rtl/rule110_frame_rx.sv
// Reassembles 16-bit words into 256-cell generations and checks each one against
// the Rule 110 step of the previous generation.
//
// Handshake: word_in/sof are consumed on every posedge where word_valid=1; there
// is no backpressure. frame_valid, mismatch and sync_err are single-cycle pulses
// that appear the cycle after the word that caused them.
module rule110_frame_rx
  import rule110_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WORD-1:0]  word_in,
  input  logic             word_valid,
  input  logic             sof,
  input  logic             check_en,
  output logic [CELLS-1:0] frame_out,
  output logic             frame_valid,
  output logic             mismatch,
  output logic             sync_err,
  output logic [15:0]      frame_count,
  output logic [7:0]       err_count,
  output rx_state_e        state_dbg
);
  rx_state_e        state_q;
  logic [3:0]       idx_q;
  logic [CELLS-1:0] asm_q;
  logic [CELLS-1:0] frame_q;
  logic [CELLS-1:0] prev_q;
  logic             have_prev_q;
  logic             frame_valid_q;
  logic             mismatch_q;
  logic             sync_err_q;
  logic [15:0]      frame_count_q;
  logic [7:0]       err_count_q;

  logic [CELLS-1:0] asm_d;
  logic [CELLS-1:0] expected;
  logic             last_word;
  logic             mismatch_d;

  rule110_step u_step (
    .cur_i (prev_q),
    .nxt_o (expected)
  );

  // Words arrive in slot order, so a shift register places word 0 at [255:240]
  // once the 16th word is shifted in; an aborted frame is simply shifted out.
  assign asm_d      = {asm_q[CELLS-WORD-1:0], word_in};
  assign last_word  = (idx_q == 4'(WORDS - 1));
  assign mismatch_d = check_en & have_prev_q & (asm_d != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      asm_q         <= '0;
      frame_q       <= '0;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      mismatch_q    <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      mismatch_q    <= 1'b0;
      sync_err_q    <= 1'b0;
      if (word_valid) begin
        case (state_q)
          IDLE: begin
            if (sof) begin
              asm_q   <= asm_d;
              idx_q   <= 4'd1;
              state_q <= RECV;
            end else begin
              sync_err_q <= 1'b1;
            end
          end
          RECV: begin
            asm_q <= asm_d;
            if (sof) begin
              sync_err_q <= 1'b1;
              idx_q      <= 4'd1;
            end else begin
              idx_q <= idx_q + 4'd1;
              if (last_word) begin
                frame_q       <= asm_d;
                prev_q        <= asm_d;
                have_prev_q   <= 1'b1;
                frame_valid_q <= 1'b1;
                mismatch_q    <= mismatch_d;
                frame_count_q <= frame_count_q + 16'd1;
                if (mismatch_d && (err_count_q != 8'hFF)) begin
                  err_count_q <= err_count_q + 8'd1;
                end
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = frame_valid_q;
  assign mismatch    = mismatch_q;
  assign sync_err    = sync_err_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_rule110_frame_rx.sv
// Bench for rule110_frame_rx: fixed vector table, hand-written framing sequences,
// and randomized frames scored against a cell-by-cell Rule 110 model.
module tb_rule110_frame_rx;
  import rule110_pkg::*;

  logic             clk;
  logic             rst;
  logic [15:0]      word_in;
  logic             word_valid;
  logic             sof;
  logic             check_en;
  logic [255:0]     frame_out;
  logic             frame_valid;
  logic             mismatch;
  logic             sync_err;
  logic [15:0]      frame_count;
  logic [7:0]       err_count;
  rx_state_e        state_dbg;

  rule110_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .sof         (sof),
    .check_en    (check_en),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .mismatch    (mismatch),
    .sync_err    (sync_err),
    .frame_count (frame_count),
    .err_count   (err_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [255:0] m_prev;
  bit           m_have_prev;
  logic [15:0]  m_count;
  logic [7:0]   m_err;

  logic [255:0] exp_q[$];
  logic         exp_mm_q[$];
  logic [15:0]  exp_cnt_q[$];
  logic [7:0]   exp_err_q[$];

  // Rule 110: new cell = bit {left,centre,right} of the rule number 110.
  function automatic logic [255:0] ref_step(input logic [255:0] p);
    logic [255:0] n;
    logic [7:0]   rule;
    int           pat;
    rule = 8'd110;
    for (int i = 0; i < 256; i++) begin
      pat = 0;
      if (i < 255 && p[i+1]) pat += 4;
      if (p[i])              pat += 2;
      if (i > 0 && p[i-1])   pat += 1;
      n[i] = rule[pat];
    end
    return n;
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_push(input logic [255:0] f);
    logic mm;
    mm = check_en && m_have_prev && (f != ref_step(m_prev));
    m_count = m_count + 16'd1;
    if (mm && m_err != 8'd255) m_err = m_err + 8'd1;
    m_prev = f;
    m_have_prev = 1'b1;
    exp_q.push_back(f);
    exp_mm_q.push_back(mm);
    exp_cnt_q.push_back(m_count);
    exp_err_q.push_back(m_err);
  endtask

  // ---------------- monitor ----------------
  logic [255:0] last_fo;
  logic         last_mm;
  int           fv_seen = 0;
  int           sync_seen = 0;
  int           last_pulse = 0;
  int           prev_pulse = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        fv_seen++;
        prev_pulse = last_pulse;
        last_pulse = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame_valid", 1, 0);
        end else begin
          check("frame_out", frame_out, exp_q.pop_front());
          check("mismatch", mismatch, exp_mm_q.pop_front());
          check("frame_count", frame_count, exp_cnt_q.pop_front());
          check("err_count", err_count, exp_err_q.pop_front());
        end
        last_fo = frame_out;
        last_mm = mismatch;
      end else begin
        check("mismatch_without_valid", mismatch, 0);
        check("frame_out_stable", frame_out, last_fo);
      end
      if (sync_err) sync_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    word_valid = 1'b0;
    sof = 1'b0;
    @(posedge clk);
    #1;
    m_prev = '0;
    m_have_prev = 1'b0;
    m_count = '0;
    m_err = '0;
    exp_q.delete();
    exp_mm_q.delete();
    exp_cnt_q.delete();
    exp_err_q.delete();
    last_fo = '0;
    last_mm = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    word_valid = 1'b0;
    sof = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic s);
    word_in = w;
    word_valid = 1'b1;
    sof = s;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_frame(input logic [255:0] f, input bit gaps);
    for (int w = 0; w < 16; w++) begin
      if (w == 15) model_push(f);
      send_word(f[255-16*w -: 16], w == 0);
      if (gaps && w < 15 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_out"}, frame_out, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_sync_err"}, sync_err, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [255:0] frame;
    logic         chk;
    logic         exp_mm;
    logic [7:0]   exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int fv0;
    int sy0;
    logic [15:0] cnt0;
    logic [255:0] f;

    vecs[0] = '{frame: 256'h3, chk: 1'b0, exp_mm: 1'b0, exp_err: 8'd0};
    vecs[1] = '{frame: 256'h1, chk: 1'b1, exp_mm: 1'b1, exp_err: 8'd1};
    vecs[2] = '{frame: 256'h3, chk: 1'b1, exp_mm: 1'b0, exp_err: 8'd1};
    vecs[3] = '{frame: 256'h5, chk: 1'b1, exp_mm: 1'b1, exp_err: 8'd2};

    word_in = '0;
    word_valid = 1'b0;
    sof = 1'b0;
    check_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    check_reset_outputs("reset");

    // Table: single frame, then consistency h1 -> h3 -> h5.
    for (int i = 0; i < 4; i++) begin
      check_en = vecs[i].chk;
      fv0 = fv_seen;
      send_frame(vecs[i].frame, 1'b0);
      wait_drain();
      check("tbl_frame_out", frame_out, vecs[i].frame);
      check("tbl_mismatch", last_mm, vecs[i].exp_mm);
      check("tbl_err_count", err_count, vecs[i].exp_err);
      check("tbl_frame_count", frame_count, 16'(i + 1));
      check("tbl_one_pulse", fv_seen - fv0, 1);
      idle(2);
    end

    // Framing: aborted 7-word frame then a full frame.
    check_en = 1'b1;
    fv0 = fv_seen;
    sy0 = sync_seen;
    f = rand_frame();
    for (int w = 0; w < 7; w++) send_word(f[255-16*w -: 16], w == 0);
    f = ref_step(m_prev);
    send_frame(f, 1'b0);
    wait_drain();
    idle(2);
    check("abort_sync_err", sync_seen - sy0, 1);
    check("abort_frame_valid", fv_seen - fv0, 1);
    check("abort_frame_out", frame_out, f);

    // Stray words in IDLE.
    fv0 = fv_seen;
    sy0 = sync_seen;
    cnt0 = frame_count;
    for (int k = 0; k < 3; k++) send_word(16'($urandom()), 1'b0);
    idle(2);
    check("stray_sync_err", sync_seen - sy0, 3);
    check("stray_frame_valid", fv_seen - fv0, 0);
    check("stray_frame_count", frame_count, cnt0);
    check("stray_state", state_dbg, IDLE);

    // Gapped frame A followed immediately by frame B.
    fv0 = fv_seen;
    send_frame(rand_frame(), 1'b1);
    send_frame(ref_step(m_prev), 1'b0);
    wait_drain();
    idle(2);
    check("b2b_pulses", fv_seen - fv0, 2);
    check("b2b_spacing", last_pulse - prev_pulse, 16);
    check("b2b_frame_out", frame_out, m_prev);

    // Randomized frames: mix of consistent and random generations.
    for (int n = 0; n < 24; n++) begin
      check_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) f = ref_step(m_prev);
      else f = rand_frame();
      send_frame(f, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    wait_drain();
    idle(2);

    // Reset at word 9, then an unchecked first frame.
    fv0 = fv_seen;
    f = rand_frame();
    for (int w = 0; w < 9; w++) send_word(f[255-16*w -: 16], w == 0);
    do_reset();
    check_reset_outputs("midreset");
    idle(20);
    check("midreset_no_frame", fv_seen - fv0, 0);
    check_en = 1'b1;
    send_frame(rand_frame(), 1'b0);
    wait_drain();
    check("midreset_unchecked", last_mm, 0);
    check("midreset_count", frame_count, 1);

    // Saturation: 300 mismatching frames.
    for (int n = 0; n < 300; n++) send_frame(256'h1, 1'b0);
    wait_drain();
    idle(2);
    check("sat_err_count", err_count, 8'd255);
    check("sat_frame_count", frame_count, 16'd301);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
